// File: rtl/result_bcd_converter_if.sv
// Result bus between the divider (master) and the BCD converter (slave).
// The display side reads the converter's packed BCD and status through the same bundle.
interface result_bcd_converter_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic [WIDTH-1:0]      quotient;
  logic [WIDTH-1:0]      remainder;
  logic [4*DIGITS-1:0]   q_bcd;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  busy;
  logic                  done;
  logic                  overrun;

  modport master (
    output in_valid, quotient, remainder,
    input  q_bcd, r_bcd, busy, done, overrun
  );

  modport slave (
    input  in_valid, quotient, remainder,
    output q_bcd, r_bcd, busy, done, overrun
  );
endinterface

// File: rtl/result_bcd_converter.sv
// Converts the divider's quotient and remainder to packed BCD with one shared
// shift-add-3 engine, quotient first, then remainder; outputs update together on done.
module result_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  result_bcd_converter_if.slave   bus
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R} state_t;

  state_t          state_reg;
  logic [SW-1:0]   shift_reg;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   step_next;
  logic [WIDTH-1:0] rem_hold_reg;
  logic [BW-1:0]   q_res_reg;
  logic [CW-1:0]   cnt_reg;
  logic [BW-1:0]   q_bcd_reg;
  logic [BW-1:0]   r_bcd_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            overrun_reg;

  // Per-nibble correction; each nibble saturates locally, no carry into the next.
  assign adj[WIDTH-1:0] = shift_reg[WIDTH-1:0];
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = shift_reg[WIDTH + 4*gi +: 4];
      assign adj[WIDTH + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign step_next = {adj[SW-2:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      rem_hold_reg <= '0;
      q_res_reg    <= '0;
      cnt_reg      <= '0;
      q_bcd_reg    <= '0;
      r_bcd_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            rem_hold_reg <= bus.remainder;
            shift_reg    <= {{BW{1'b0}}, bus.quotient};
            cnt_reg      <= '0;
            overrun_reg  <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= CONV_Q;
          end
        end
        CONV_Q: begin
          if (bus.in_valid) overrun_reg <= 1'b1;
          if (cnt_reg == LAST_STEP) begin
            q_res_reg <= step_next[SW-1:WIDTH];
            shift_reg <= {{BW{1'b0}}, rem_hold_reg};
            cnt_reg   <= '0;
            state_reg <= CONV_R;
          end else begin
            shift_reg <= step_next;
            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
        CONV_R: begin
          if (bus.in_valid) overrun_reg <= 1'b1;
          if (cnt_reg == LAST_STEP) begin
            q_bcd_reg <= q_res_reg;
            r_bcd_reg <= step_next[SW-1:WIDTH];
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            shift_reg <= step_next;
            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.q_bcd   = q_bcd_reg;
  assign bus.r_bcd   = r_bcd_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.overrun = overrun_reg;
endmodule

// File: tb/tb_result_bcd_converter.sv
// Bench for result_bcd_converter: vector table through a done-driven scoreboard,
// plus overrun, mid-conversion reset and output-hold sequences.
module tb_result_bcd_converter;
  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int LAT    = 2 * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  result_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic [19:0] exp_q;
    logic [19:0] exp_r;
  } vec_t;

  typedef struct {
    logic [19:0] q;
    logic [19:0] r;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] prev_q = '0;
  logic [19:0] prev_r = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] res;
    int x;
    res = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      res[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding conversion.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q_bcd", 32'(bus.q_bcd), 32'(e.q));
        check("r_bcd", 32'(bus.r_bcd), 32'(e.r));
        $display("done: q_bcd=%h r_bcd=%h (expect %h %h)", bus.q_bcd, bus.r_bcd, e.q, e.r);
      end
    end
  end

  // Called right after the accepting edge; checks hold, latency and the done pulse.
  task automatic wait_done(input logic [19:0] eq, input logic [19:0] er);
    int  n;
    bit  held;
    n = 0;
    held = 1'b1;
    while (!bus.done && n < LAT + 8) begin
      if (bus.q_bcd !== prev_q || bus.r_bcd !== prev_r || bus.busy !== 1'b1) held = 1'b0;
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(LAT));
    check("held_during_conv", 32'(held), 32'd1);
    if (bus.done) begin
      check("busy_at_done", 32'(bus.busy), 32'd0);
      tick();
      check("done_one_cycle", 32'(bus.done), 32'd0);
    end
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic run_one(input vec_t v);
    bus.in_valid  = 1'b1;
    bus.quotient  = v.q;
    bus.remainder = v.r;
    sb.push_back('{q: v.exp_q, r: v.exp_r});
    tick();
    bus.in_valid = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    wait_done(v.exp_q, v.exp_r);
    $display("vector q=%0d r=%0d -> q_bcd=%h r_bcd=%h", v.q, v.r, bus.q_bcd, bus.r_bcd);
  endtask

  vec_t vecs[10];

  initial begin
    vec_t a, c, x, fin;
    int dones;

    vecs[0] = '{16'd1234,  16'd56,    20'h01234, 20'h00056};
    vecs[1] = '{16'd65535, 16'd0,     20'h65535, 20'h00000};
    vecs[2] = '{16'd9999,  16'd10000, 20'h09999, 20'h10000};
    vecs[3] = '{16'd5,     16'd59999, 20'h00005, 20'h59999};
    for (int i = 4; i < 8; i++) begin
      int qv, rv;
      qv = int'($urandom_range(0, 65535));
      rv = int'($urandom_range(0, 65535));
      vecs[i] = '{16'(qv), 16'(rv), to_bcd(qv), to_bcd(rv)};
    end
    vecs[8] = '{16'd14, 16'd2, 20'h00014, 20'h00002};
    vecs[9] = '{16'd0,  16'd0, 20'h00000, 20'h00000};

    bus.in_valid  = 1'b0;
    bus.quotient  = '0;
    bus.remainder = '0;
    tick();
    tick();
    check("rst_q_bcd",   32'(bus.q_bcd),   32'd0);
    check("rst_r_bcd",   32'(bus.r_bcd),   32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_one(vecs[i]);

    // Strobes at E16 and E32 are dropped; the one in the done cycle is accepted.
    a = '{16'd4321, 16'd87, 20'h04321, 20'h00087};
    c = '{16'd777,  16'd3,  20'h00777, 20'h00003};
    bus.in_valid = 1'b1; bus.quotient = a.q; bus.remainder = a.r;
    sb.push_back('{q: a.exp_q, r: a.exp_r});
    tick();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 15; k++) tick();
    bus.in_valid = 1'b1; bus.quotient = 16'd1111; bus.remainder = 16'd2222;
    tick();
    bus.in_valid = 1'b0;
    check("overrun_e16", 32'(bus.overrun), 32'd1);
    check("busy_e16",    32'(bus.busy),    32'd1);
    for (int k = 17; k <= 31; k++) tick();
    bus.in_valid = 1'b1; bus.quotient = 16'd3333; bus.remainder = 16'd4444;
    tick();
    check("done_e32",    32'(bus.done),    32'd1);
    check("overrun_e32", 32'(bus.overrun), 32'd1);
    check("q_bcd_e32",   32'(bus.q_bcd),   32'(a.exp_q));
    bus.quotient = c.q; bus.remainder = c.r;
    sb.push_back('{q: c.exp_q, r: c.exp_r});
    tick();
    bus.in_valid = 1'b0;
    check("overrun_cleared", 32'(bus.overrun), 32'd0);
    check("busy_rearmed",    32'(bus.busy),    32'd1);
    check("done_dropped",    32'(bus.done),    32'd0);
    prev_q = a.exp_q;
    prev_r = a.exp_r;
    wait_done(c.exp_q, c.exp_r);
    $display("back-to-back: q_bcd=%h r_bcd=%h", bus.q_bcd, bus.r_bcd);

    // Reset at E10 with overrun already set must clear everything at once.
    x = '{16'd2468, 16'd13, 20'h02468, 20'h00013};
    bus.in_valid = 1'b1; bus.quotient = x.q; bus.remainder = x.r;
    sb.push_back('{q: x.exp_q, r: x.exp_r});
    tick();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("overrun_e5", 32'(bus.overrun), 32'd1);
    for (int k = 6; k <= 10; k++) tick();
    rst = 1'b1;
    sb.delete();
    #1;
    check("abort_busy",    32'(bus.busy),    32'd0);
    check("abort_q_bcd",   32'(bus.q_bcd),   32'd0);
    check("abort_r_bcd",   32'(bus.r_bcd),   32'd0);
    check("abort_overrun", 32'(bus.overrun), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    prev_q = '0;
    prev_r = '0;
    dones = 0;
    for (int k = 0; k < LAT + 8; k++) begin
      if (bus.done) dones++;
      tick();
    end
    check("no_done_after_abort", 32'(dones), 32'd0);
    $display("abort: done pulses after reset = %0d", dones);

    fin = '{16'd100, 16'd99, 20'h00100, 20'h00099};
    run_one(fin);
    tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
